// File: rtl/twin_word_tx.sv
// twin_word_tx: serialises a pair of 8-bit words as one framed packet.
//   Frame: start(0) | d1 LSB-first | d2 LSB-first | [even parity] | stop(1),
//   each bit held DIV clock cycles.
// Optional feature: define TWIN_TX_PARITY_EN to insert an even-parity bit
//   (XOR of all 16 data bits) between the second word and the stop bit.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   d1, d2     - word pair, sampled only at the load handshake
//   load_valid - source offers a pair
//   load_ready - high only while idle
//   sdo        - registered serial output, idles high
//   busy       - high while a frame is in flight
//   done       - one-cycle pulse on the final stop-bit cycle
module twin_word_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       sdo,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData1  = 3'd2;
  localparam logic [2:0] StData2  = 3'd3;
  localparam logic [2:0] StParity = 3'd4;
  localparam logic [2:0] StStop   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh1_q, sh1_d;
  logic [7:0]    sh2_q, sh2_d;
  logic          sdo_q, sdo_d;
  logic          bit_end;

`ifdef TWIN_TX_PARITY_EN
  logic par_q, par_d;
`endif

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    sdo_d   = sdo_q;
`ifdef TWIN_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Bit-period counter free-runs in every non-idle state.
    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      StIdle: begin
        sdo_d = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (load_valid) begin
          sh1_d   = d1;
          sh2_d   = d2;
          sdo_d   = 1'b0;
          state_d = StStart;
`ifdef TWIN_TX_PARITY_EN
          par_d   = ^{d1, d2};
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          sdo_d   = sh1_q[0];
          sh1_d   = sh1_q >> 1;
          idx_d   = '0;
          state_d = StData1;
        end
      end
      StData1: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            sdo_d   = sh2_q[0];
            sh2_d   = sh2_q >> 1;
            idx_d   = '0;
            state_d = StData2;
          end else begin
            sdo_d = sh1_q[0];
            sh1_d = sh1_q >> 1;
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StData2: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d   = '0;
`ifdef TWIN_TX_PARITY_EN
            sdo_d   = par_q;
            state_d = StParity;
`else
            sdo_d   = 1'b1;
            state_d = StStop;
`endif
          end else begin
            sdo_d = sh2_q[0];
            sh2_d = sh2_q >> 1;
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef TWIN_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          sdo_d   = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          sdo_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        sdo_d   = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sdo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      sdo_q   <= sdo_d;
    end
  end

`ifdef TWIN_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // Status outputs decode the state register directly so an asynchronous
  // reset clears busy without waiting for a clock.
  assign load_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StStop) && bit_end;
  assign sdo        = sdo_q;

endmodule

// File: tb/tb_twin_word_tx.sv
// Directed testbench for twin_word_tx: one DIV=4 instance and one DIV=1 instance.
module tb_twin_word_tx;

`ifdef TWIN_TX_PARITY_EN
  localparam int FL = 19;
`else
  localparam int FL = 18;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] d1a, d2a, d1b, d2b;
  logic       lva, lvb;
  logic       lra, lrb, sdoa, sdob, busya, busyb, donea, doneb;

  int checks;
  int errors;

  twin_word_tx #(.DIV(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .d1        (d1a),
    .d2        (d2a),
    .load_valid(lva),
    .load_ready(lra),
    .sdo       (sdoa),
    .busy      (busya),
    .done      (donea)
  );

  twin_word_tx #(.DIV(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .d1        (d1b),
    .d2        (d2b),
    .load_valid(lvb),
    .load_ready(lrb),
    .sdo       (sdob),
    .busy      (busyb),
    .done      (doneb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Frame bit i at index i: start, d1 LSB-first, d2 LSB-first, [parity], stop.
  function automatic logic [18:0] frame_bits(input logic [7:0] a, input logic [7:0] b,
                                             input logic p);
`ifdef TWIN_TX_PARITY_EN
    frame_bits = {1'b1, p, b, a, 1'b0};
`else
    frame_bits = {1'b0, 1'b1, b, a, 1'b0};
`endif
  endfunction

  // Called just after the accept edge; checks every cycle of the frame.
  task automatic check_frame(input int div, input logic [18:0] exp, input string name);
    logic s, bz, dn, rdy;
    int   bi;
    for (int c = 1; c <= FL * div; c++) begin
      @(negedge clk);
      s   = (div == 1) ? sdob  : sdoa;
      bz  = (div == 1) ? busyb : busya;
      dn  = (div == 1) ? doneb : donea;
      rdy = (div == 1) ? lrb   : lra;
      bi  = (c - 1) / div;
      checks++;
      if (s !== exp[bi]) begin
        errors++;
        $display("FAIL %s sdo cycle %0d: got %b want %b", name, c, s, exp[bi]);
      end
      checks++;
      if (dn !== (c == FL * div)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want %b", name, c, dn, (c == FL * div));
      end
      checks++;
      if (bz !== 1'b1 || rdy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/ready cycle %0d: got %b/%b want 1/0", name, c, bz, rdy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    lva = 1'b1; lvb = 1'b1;
    d1a = 8'h5A; d2a = 8'hA5; d1b = 8'h5A; d2b = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sdoa !== 1'b1 || lra !== 1'b1 || busya !== 1'b0 || donea !== 1'b0) begin
        errors++;
        $display("FAIL reset dut4: sdo/ready/busy/done got %b%b%b%b want 1100",
                 sdoa, lra, busya, donea);
      end
      checks++;
      if (sdob !== 1'b1 || lrb !== 1'b1 || busyb !== 1'b0 || doneb !== 1'b0) begin
        errors++;
        $display("FAIL reset dut1: sdo/ready/busy/done got %b%b%b%b want 1100",
                 sdob, lrb, busyb, doneb);
      end
    end
    lva = 1'b0; lvb = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (busya !== 1'b0 || sdoa !== 1'b1 || busyb !== 1'b0 || sdob !== 1'b1) begin
        errors++;
        $display("FAIL reset release: busy/sdo got %b%b %b%b want 01 01",
                 busya, sdoa, busyb, sdob);
      end
    end
  endtask

  task automatic test_basic;
    @(negedge clk);
    d1a = 8'd52; d2a = 8'd45; lva = 1'b1;
    checks++;
    if (lra !== 1'b1) begin
      errors++;
      $display("FAIL basic ready before accept: got %b want 1", lra);
    end
    @(posedge clk);
    #1 lva = 1'b0;
    // 52 and 45 hold seven ones in total, so even parity is 1.
    check_frame(4, frame_bits(8'd52, 8'd45, 1'b1), "basic");
  endtask

  task automatic test_busy_ignore;
    @(negedge clk);
    d1a = 8'd52; d2a = 8'd45; lva = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        repeat (20) @(posedge clk);
        #1 d1a = 8'd11; d2a = 8'd16;
      end
      check_frame(4, frame_bits(8'd52, 8'd45, 1'b1), "busy_first");
    join
    // One idle cycle after done; load_valid is still high.
    @(negedge clk);
    checks++;
    if (lra !== 1'b1 || busya !== 1'b0 || sdoa !== 1'b1) begin
      errors++;
      $display("FAIL busy gap: ready/busy/sdo got %b%b%b want 101", lra, busya, sdoa);
    end
    @(posedge clk);
    #1 lva = 1'b0;
    // 11 and 16 hold four ones: parity 0.
    check_frame(4, frame_bits(8'd11, 8'd16, 1'b0), "busy_second");
  endtask

  task automatic test_div1;
    @(negedge clk);
    d1b = 8'hFF; d2b = 8'h00; lvb = 1'b1;
    @(posedge clk);
    #1 lvb = 1'b0;
    check_frame(1, frame_bits(8'hFF, 8'h00, 1'b0), "div1");
  endtask

  task automatic test_midframe_reset;
    @(negedge clk);
    d1a = 8'd63; d2a = 8'd59; lva = 1'b1;
    @(posedge clk);
    #1 lva = 1'b0;
    // Cycle 45 carries d2 bit 2 of 59, which is 0.
    repeat (45) @(negedge clk);
    checks++;
    if (busya !== 1'b1 || sdoa !== 1'b0) begin
      errors++;
      $display("FAIL midreset pre: busy/sdo got %b%b want 10", busya, sdoa);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sdoa !== 1'b1 || busya !== 1'b0 || donea !== 1'b0 || lra !== 1'b1) begin
      errors++;
      $display("FAIL midreset async: sdo/busy/done/ready got %b%b%b%b want 1001",
               sdoa, busya, donea, lra);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (donea !== 1'b0 || busya !== 1'b0 || sdoa !== 1'b1) begin
        errors++;
        $display("FAIL midreset abandoned cycle %0d: done/busy/sdo got %b%b%b want 001",
                 i, donea, busya, sdoa);
      end
    end
    d1a = 8'd36; d2a = 8'd9; lva = 1'b1;
    @(posedge clk);
    #1 lva = 1'b0;
    // 36 and 9 hold four ones: parity 0.
    check_frame(4, frame_bits(8'd36, 8'd9, 1'b0), "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_busy_ignore();
    test_div1();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
